// File: rtl/ft245_si_bridge_if.sv
// Simple-interface byte streams between the FT245 bridge (master) and the
// register decoder / tx arbiter (slave).
interface ft245_si_bridge_if #(
  parameter int FT245_WIDTH = 8
);
  logic [FT245_WIDTH-1:0] rx_data_si;
  logic                   rx_rdy_si;
  logic                   rx_ack_si;
  logic [FT245_WIDTH-1:0] tx_data_si;
  logic                   tx_rdy_si;
  logic                   tx_ack_si;

  modport master (
    output rx_data_si, rx_rdy_si, tx_ack_si,
    input  rx_ack_si, tx_data_si, tx_rdy_si
  );

  modport slave (
    input  rx_data_si, rx_rdy_si, tx_ack_si,
    output rx_ack_si, tx_data_si, tx_rdy_si
  );
endinterface

// File: rtl/ft245_si_bridge.sv
// FT245 asynchronous FIFO to SI byte-stream bridge with strobe timing and flag sync.
// Define FT245_TX_PRIORITY_EN to let a write win over a simultaneous read request.
module ft245_si_bridge #(
  parameter int FT245_WIDTH     = 8,
  parameter int CLOCK_PERIOD_NS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [FT245_WIDTH-1:0] in_out_245,
  input  logic                   rxf_245,
  output logic                   rx_245,
  input  logic                   txe_245,
  output logic                   wr_245,
  ft245_si_bridge_if.master      si
);
  localparam int T_STROBE  = (50 + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;
  localparam int T_RECOVER = (50 + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;
  localparam int T_SETUP   = (20 + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_STROBE  = 3'd1,
    RX_RECOVER = 3'd2,
    TX_SETUP   = 3'd3,
    TX_STROBE  = 3'd4,
    TX_RECOVER = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic                   rxf_meta, rxf_s, txe_meta, txe_s;
  logic                   rx_req, tx_req, grant_rx, grant_tx;
  logic                   rx_strb, rx_strb_nxt;
  logic                   wr_strb, wr_strb_nxt;
  logic                   drive, drive_nxt;
  logic                   tx_ack, tx_ack_nxt;
  logic                   rx_rdy, rx_rdy_nxt;
  logic [FT245_WIDTH-1:0] rx_data, rx_data_nxt;
  logic [FT245_WIDTH-1:0] tx_hold, tx_hold_nxt;

  assign rx_req = !rxf_s && !rx_rdy;
  assign tx_req = !txe_s && si.tx_rdy_si;

`ifdef FT245_TX_PRIORITY_EN
  assign grant_tx = tx_req;
  assign grant_rx = rx_req && !tx_req;
`else
  assign grant_rx = rx_req;
  assign grant_tx = tx_req && !rx_req;
`endif

  // State, timer, synchronisers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
      rx_strb  <= 1'b1;
      wr_strb  <= 1'b0;
      drive    <= 1'b0;
      tx_ack   <= 1'b0;
      rx_rdy   <= 1'b0;
      rx_data  <= {FT245_WIDTH{1'b0}};
      tx_hold  <= {FT245_WIDTH{1'b0}};
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rxf_meta <= rxf_245;
      rxf_s    <= rxf_meta;
      txe_meta <= txe_245;
      txe_s    <= txe_meta;
      rx_strb  <= rx_strb_nxt;
      wr_strb  <= wr_strb_nxt;
      drive    <= drive_nxt;
      tx_ack   <= tx_ack_nxt;
      rx_rdy   <= rx_rdy_nxt;
      rx_data  <= rx_data_nxt;
      tx_hold  <= tx_hold_nxt;
    end
  end

  // Next state; the counter is loaded with the phase length minus one on entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_rx) begin
          state_nxt = RX_STROBE;
          cnt_nxt   = 8'(T_STROBE - 1);
        end else if (grant_tx) begin
          state_nxt = TX_SETUP;
          cnt_nxt   = 8'(T_SETUP - 1);
        end else begin
          cnt_nxt   = 8'd0;
        end
      end
      RX_STROBE: begin
        if (cnt == 8'd0) begin
          state_nxt = RX_RECOVER;
          cnt_nxt   = 8'(T_RECOVER - 1);
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      RX_RECOVER, TX_RECOVER: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      TX_SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = TX_STROBE;
          cnt_nxt   = 8'(T_STROBE - 1);
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      TX_STROBE: begin
        if (cnt == 8'd0) begin
          state_nxt = TX_RECOVER;
          cnt_nxt   = 8'(T_RECOVER - 1);
        end else begin
          cnt_nxt   = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output next-values, decoded from the state being entered so pins are registered
  always_comb begin
    rx_strb_nxt = 1'b1;
    wr_strb_nxt = 1'b0;
    drive_nxt   = 1'b0;
    tx_ack_nxt  = 1'b0;
    tx_hold_nxt = tx_hold;
    rx_data_nxt = rx_data;
    rx_rdy_nxt  = rx_rdy;
    case (state_nxt)
      RX_STROBE:  rx_strb_nxt = 1'b0;
      TX_SETUP:   drive_nxt   = 1'b1;
      TX_STROBE: begin
        drive_nxt   = 1'b1;
        wr_strb_nxt = 1'b1;
      end
      TX_RECOVER: drive_nxt   = 1'b1;
      default:    drive_nxt   = 1'b0;
    endcase
    if (rx_rdy && si.rx_ack_si) begin
      rx_rdy_nxt = 1'b0;
    end else begin
      rx_rdy_nxt = rx_rdy;
    end
    if ((state == RX_STROBE) && (state_nxt == RX_RECOVER)) begin
      rx_data_nxt = in_out_245;
      rx_rdy_nxt  = 1'b1;
    end else begin
      rx_data_nxt = rx_data;
    end
    if ((state == IDLE) && (state_nxt == TX_SETUP)) begin
      tx_ack_nxt  = 1'b1;
      tx_hold_nxt = si.tx_data_si;
    end else begin
      tx_ack_nxt  = 1'b0;
    end
  end

  assign in_out_245    = drive ? tx_hold : {FT245_WIDTH{1'bz}};
  assign rx_245        = rx_strb;
  assign wr_245        = wr_strb;
  assign si.rx_data_si = rx_data;
  assign si.rx_rdy_si  = rx_rdy;
  assign si.tx_ack_si  = tx_ack;
endmodule

// File: tb/tb_ft245_si_bridge.sv
// Self-checking bench for ft245_si_bridge: models the FT245 chip side and the SI
// consumer/producer, with byte scoreboards for both directions.
module tb_ft245_si_bridge;
  localparam int W = 8;
`ifdef FT245_TX_PRIORITY_EN
  localparam bit TX_FIRST = 1'b1;
`else
  localparam bit TX_FIRST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rxf_245;
  logic         txe_245;
  logic         rx_245;
  logic         wr_245;
  tri1  [W-1:0] in_out_245;
  logic [W-1:0] tb_bus;

  ft245_si_bridge_if #(.FT245_WIDTH(W)) si ();

  // The modelled chip drives the bus only while the read strobe is low
  assign in_out_245 = (rx_245 == 1'b0) ? tb_bus : {W{1'bz}};

  ft245_si_bridge #(.FT245_WIDTH(W), .CLOCK_PERIOD_NS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_out_245 (in_out_245),
    .rxf_245    (rxf_245),
    .rx_245     (rx_245),
    .txe_245    (txe_245),
    .wr_245     (wr_245),
    .si         (si)
  );

  always #5 clk = ~clk;

  int           pass_cnt  = 0;
  int           total_cnt = 0;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] exp_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int strobes;
    strobes = 0;
    rst = 1'b1; rxf_245 = 1'b0; txe_245 = 1'b0; tb_bus = 8'h00;
    si.rx_ack_si = 1'b0; si.tx_rdy_si = 1'b1; si.tx_data_si = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rx_245 !== 1'b1 || wr_245 !== 1'b0 || si.tx_ack_si !== 1'b0) strobes++;
    end
    total_cnt++;
    if (strobes !== 0) $display("FAIL reset_strobes got %0d active cycles, want 0", strobes);
    else pass_cnt++;
    total_cnt++;
    if (in_out_245 !== 8'hff) $display("FAIL reset_bus got %h, want released (ff)", in_out_245);
    else pass_cnt++;
    total_cnt++;
    if (si.rx_rdy_si !== 1'b0 || si.rx_data_si !== 8'h00)
      $display("FAIL reset_rx got rdy=%b data=%h, want rdy=0 data=00", si.rx_rdy_si, si.rx_data_si);
    else pass_cnt++;
    rxf_245 = 1'b1; txe_245 = 1'b1; si.tx_rdy_si = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_read();
    int n;
    logic [W-1:0] held;
    tb_bus = 8'hA5;
    rx_q.push_back(8'hA5);
    rxf_245 = 1'b0;
    n = 0;
    while (rx_245 !== 1'b0 && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n !== 3) $display("FAIL rx_latency got %0d cycles, want 3", n);
    else pass_cnt++;
    rxf_245 = 1'b1;
    n = 0;
    while (rx_245 === 1'b0 && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n !== 5) $display("FAIL rx_strobe_width got %0d cycles, want 5", n);
    else pass_cnt++;
    exp_b = rx_q.pop_front();
    total_cnt++;
    if (si.rx_rdy_si !== 1'b1 || si.rx_data_si !== exp_b)
      $display("FAIL rx_byte got rdy=%b data=%h, want rdy=1 data=%h", si.rx_rdy_si, si.rx_data_si, exp_b);
    else pass_cnt++;
    held = exp_b;
    tb_bus = 8'h00;
    repeat (3) tick();
    total_cnt++;
    if (si.rx_data_si !== held || si.rx_rdy_si !== 1'b1)
      $display("FAIL rx_hold got rdy=%b data=%h, want rdy=1 data=%h", si.rx_rdy_si, si.rx_data_si, held);
    else pass_cnt++;
    si.rx_ack_si = 1'b1;
    tick();
    si.rx_ack_si = 1'b0;
    total_cnt++;
    if (si.rx_rdy_si !== 1'b0) $display("FAIL rx_ack_clear got rdy=%b, want 0", si.rx_rdy_si);
    else pass_cnt++;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int n;
    int lows;
    tb_bus = 8'h5A;
    rx_q.push_back(8'h5A);
    rxf_245 = 1'b0;
    n = 0;
    while (rx_245 !== 1'b0 && n < 20) begin tick(); n++; end
    n = 0;
    while (rx_245 === 1'b0 && n < 20) begin tick(); n++; end
    exp_b = rx_q.pop_front();
    total_cnt++;
    if (si.rx_rdy_si !== 1'b1 || si.rx_data_si !== exp_b)
      $display("FAIL bp_first_byte got rdy=%b data=%h, want rdy=1 data=%h", si.rx_rdy_si, si.rx_data_si, exp_b);
    else pass_cnt++;
    lows = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rx_245 !== 1'b1) lows++;
    end
    total_cnt++;
    if (lows !== 0) $display("FAIL bp_no_read got %0d strobe cycles while held, want 0", lows);
    else pass_cnt++;
    tb_bus = 8'h96;
    rx_q.push_back(8'h96);
    si.rx_ack_si = 1'b1;
    tick();
    si.rx_ack_si = 1'b0;
    n = 0;
    while (rx_245 !== 1'b0 && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n !== 1) $display("FAIL bp_resume got %0d cycles after ack, want 1", n);
    else pass_cnt++;
    rxf_245 = 1'b1;
    n = 0;
    while (rx_245 === 1'b0 && n < 20) begin tick(); n++; end
    exp_b = rx_q.pop_front();
    total_cnt++;
    if (si.rx_rdy_si !== 1'b1 || si.rx_data_si !== exp_b)
      $display("FAIL bp_second_byte got rdy=%b data=%h, want rdy=1 data=%h", si.rx_rdy_si, si.rx_data_si, exp_b);
    else pass_cnt++;
    si.rx_ack_si = 1'b1;
    tick();
    si.rx_ack_si = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_single_write();
    int n;
    int bad;
    int first_bad;
    int acks;
    logic [W-1:0] cur;
    logic         exp_wr;
    logic [W-1:0] exp_bus;
    txe_245 = 1'b0; si.tx_rdy_si = 1'b1; si.tx_data_si = 8'h3C;
    tx_q.push_back(8'h3C);
    n = 0;
    while (si.tx_ack_si !== 1'b1 && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n !== 3) $display("FAIL tx_ack_latency got %0d cycles, want 3", n);
    else pass_cnt++;
    si.tx_rdy_si = 1'b0; si.tx_data_si = 8'h00; txe_245 = 1'b1;
    cur = tx_q[0];
    bad = 0; first_bad = -1; acks = 0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      if (i > 0 && si.tx_ack_si === 1'b1) acks++;
      exp_wr  = (i >= 2 && i < 7);
      exp_bus = (i < 12) ? cur : 8'hff;
      if (wr_245 !== exp_wr || in_out_245 !== exp_bus) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i == 2) begin
        exp_b = tx_q.pop_front();
        total_cnt++;
        if (in_out_245 !== exp_b) $display("FAIL tx_byte got %h on bus at wr rise, want %h", in_out_245, exp_b);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL tx_trace got %0d bad cycles (first at %0d), want 0", bad, first_bad);
    else pass_cnt++;
    total_cnt++;
    if (acks !== 0) $display("FAIL tx_ack_pulse got %0d extra ack cycles, want 0", acks);
    else pass_cnt++;
  endtask

  task automatic test_write_blocked();
    int n;
    int act;
    txe_245 = 1'b1; si.tx_rdy_si = 1'b1; si.tx_data_si = 8'h69;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (si.tx_ack_si !== 1'b0 || wr_245 !== 1'b0) act++;
    end
    total_cnt++;
    if (act !== 0) $display("FAIL tx_blocked got %0d active cycles, want 0", act);
    else pass_cnt++;
    tx_q.push_back(8'h69);
    txe_245 = 1'b0;
    n = 0;
    while (si.tx_ack_si !== 1'b1 && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n !== 3) $display("FAIL tx_unblock_latency got %0d cycles, want 3", n);
    else pass_cnt++;
    si.tx_rdy_si = 1'b0; txe_245 = 1'b1;
    n = 0;
    while (wr_245 !== 1'b1 && n < 20) begin tick(); n++; end
    exp_b = tx_q.pop_front();
    total_cnt++;
    if (in_out_245 !== exp_b || n !== 2)
      $display("FAIL tx_unblock_byte got %h after %0d cycles, want %h after 2", in_out_245, n, exp_b);
    else pass_cnt++;
    n = 0;
    while (in_out_245 !== 8'hff && n < 30) begin tick(); n++; end
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    int rx_seen;
    int tx_seen;
    int exp_diff;
    rx_seen = -1; tx_seen = -1;
    tb_bus = 8'hC3;
    rx_q.push_back(8'hC3);
    rxf_245 = 1'b0; txe_245 = 1'b0; si.tx_rdy_si = 1'b1; si.tx_data_si = 8'h1E;
    for (int c = 0; c < 60; c++) begin
      tick();
      si.rx_ack_si = 1'b0;
      if (rx_245 === 1'b0 && rx_seen < 0) begin rx_seen = c; rxf_245 = 1'b1; end
      if (si.tx_ack_si === 1'b1 && tx_seen < 0) begin tx_seen = c; txe_245 = 1'b1; si.tx_rdy_si = 1'b0; end
      if (si.rx_rdy_si === 1'b1) begin
        exp_b = rx_q.pop_front();
        total_cnt++;
        if (si.rx_data_si !== exp_b) $display("FAIL sim_rx_byte got %h, want %h", si.rx_data_si, exp_b);
        else pass_cnt++;
        si.rx_ack_si = 1'b1;
      end
    end
    si.rx_ack_si = 1'b0;
    exp_diff = TX_FIRST ? 13 : -11;
    total_cnt++;
    if (rx_seen < 0 || tx_seen < 0 || (rx_seen - tx_seen) !== exp_diff)
      $display("FAIL sim_order got rx_start=%0d tx_ack=%0d, want rx-tx=%0d", rx_seen, tx_seen, exp_diff);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int n;
    int acks;
    tb_bus = 8'h77;
    rxf_245 = 1'b0;
    n = 0;
    while (rx_245 !== 1'b0 && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (rx_245 !== 1'b1 || si.rx_rdy_si !== 1'b0 || in_out_245 !== 8'hff)
      $display("FAIL abort_rx got rx=%b rdy=%b bus=%h, want rx=1 rdy=0 bus=ff", rx_245, si.rx_rdy_si, in_out_245);
    else pass_cnt++;
    rxf_245 = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    txe_245 = 1'b0; si.tx_rdy_si = 1'b1; si.tx_data_si = 8'hA0;
    n = 0;
    while (wr_245 !== 1'b1 && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    total_cnt++;
    if (wr_245 !== 1'b0 || in_out_245 !== 8'hff)
      $display("FAIL abort_tx got wr=%b bus=%h, want wr=0 bus=ff", wr_245, in_out_245);
    else pass_cnt++;
    txe_245 = 1'b1; si.tx_rdy_si = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (si.tx_ack_si !== 1'b0) acks++;
    end
    rst = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (acks !== 0) $display("FAIL abort_no_ack got %0d ack cycles, want 0", acks);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_single_write();
    test_write_blocked();
    test_simultaneous();
    test_reset_abort();
    total_cnt++;
    if (rx_q.size() !== 0 || tx_q.size() !== 0)
      $display("FAIL scoreboard_drain got rx=%0d tx=%0d pending, want 0", rx_q.size(), tx_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, want completion");
    $fatal(1);
  end
endmodule
